// File: rtl/restoring_divider.sv
// restoring_divider
//   Unsigned N-bit sequential divider using the restoring algorithm, one
//   quotient bit per clock, MSB first.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     start        request a new division (honoured in IDLE or DONE only)
//     dividend     unsigned dividend, captured on the accepting edge
//     divisor      unsigned divisor, captured on the accepting edge
//     quotient     unsigned quotient of the last completed operation
//     remainder    unsigned remainder of the last completed operation
//     busy         high while iterating
//     done         single-cycle result-valid pulse
//     div_by_zero  last accepted operation had a zero divisor
module restoring_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  // dq_q starts out holding the dividend; each iteration shifts one dividend
  // bit out of the top and one quotient bit in at the bottom, so after N
  // iterations it holds the full quotient.
  logic [N-1:0]  dq_q;
  logic [N-1:0]  dvs_q;
  logic [N:0]    rem_q;

  logic               accept;
  logic [N:0]         shifted;
  logic signed [N:0]  trial;
  logic               qbit;
  logic [N:0]         rem_nxt;
  logic [N-1:0]       dq_nxt;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // The partial remainder stays below the divisor, so the true difference
  // lies in [-divisor, divisor-1] and always fits a signed N+1-bit value.
  assign shifted = {rem_q[N-1:0], dq_q[N-1]};
  assign trial   = $signed(shifted) - $signed({1'b0, dvs_q});
  assign qbit    = (trial >= 0);
  assign rem_nxt = qbit ? $unsigned(trial) : shifted;
  assign dq_nxt  = {dq_q[N-2:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dq_q  <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      if (divisor == '0) begin
        // Zero divisor completes immediately with a saturated quotient.
        cnt_q       <= '0;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        cnt_q       <= CW'(N - 1);
        div_by_zero <= 1'b0;
      end
    end else if (state_q == RUN) begin
      dq_q  <= dq_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        quotient  <= dq_nxt;
        remainder <= rem_nxt[N-1:0];
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
//   Directed-vector bench for restoring_divider with N = 32: a table of
//   operand/result records plus hand-written sequences for start-during-RUN,
//   back-to-back start from DONE, and reset during RUN.
module tb_restoring_divider;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge, let the next rising edge accept them,
  // then scramble the inputs to show they were latched.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 32'd3;
  endtask

  // Wait (bounded) for done, counting busy cycles and watching that the
  // result outputs do not move before done.
  task automatic wait_done(output int nbusy, output bit seen, output bit stable);
    logic [N-1:0] q0;
    logic [N-1:0] r0;
    q0     = quotient;
    r0     = remainder;
    nbusy  = 0;
    seen   = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (quotient !== q0 || remainder !== r0) stable = 1'b0;
    end
  endtask

  initial begin
    int  nb;
    bit  seen;
    bit  stable;
    bit  quiet;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[2]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[3]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[6]  = '{32'h80000000,   32'h80000001,   32'd0,          32'h80000000,   1'b0};
    vecs[7]  = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};
    vecs[8]  = '{32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0};
    vecs[9]  = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};
    vecs[10] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("reset_quotient",  quotient,    0);
    chk("reset_remainder", remainder,   0);
    chk("reset_busy",      busy,        0);
    chk("reset_done",      done,        0);
    chk("reset_dz",        div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(nb, seen, stable);
      chk($sformatf("v%0d_done_seen", i), seen, 1);
      chk($sformatf("v%0d_busy_cycles", i), nb, vecs[i].dz ? 0 : N);
      chk($sformatf("v%0d_hold_in_run", i), stable, 1);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_div_by_zero", i), div_by_zero, vecs[i].dz);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), done, 0);
    end

    // start during RUN is ignored; start during DONE is taken back-to-back
    start_op(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen, stable);
    chk("run_ignore_done_seen", seen, 1);
    chk("run_ignore_busy_left", nb, 21);
    chk("run_ignore_quotient", quotient, 14);
    chk("run_ignore_remainder", remainder, 2);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'd77;
    @(negedge clk);
    chk("b2b_done_drops", done, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_hold_quotient", quotient, 14);
    wait_done(nb, seen, stable);
    chk("b2b_done_seen", seen, 1);
    chk("b2b_busy_cycles", nb, N - 1);
    chk("b2b_quotient", quotient, 3);
    chk("b2b_remainder", remainder, 0);

    // reset in the middle of an operation
    start_op(32'd100, 32'd7);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_quotient",  quotient,    0);
    chk("abort_remainder", remainder,   0);
    chk("abort_busy",      busy,        0);
    chk("abort_done",      done,        0);
    chk("abort_dz",        div_by_zero, 0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("abort_no_done", quiet, 1);
    rst_n    = 1'b1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(nb, seen, stable);
    chk("after_reset_done_seen", seen, 1);
    chk("after_reset_busy_cycles", nb, N);
    chk("after_reset_quotient", quotient, 14);
    chk("after_reset_remainder", remainder, 2);
    chk("after_reset_dz", div_by_zero, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 The block SHALL have port dividend, input, N bits: unsigned dividend, sampled on the accepting edge.
REQ-006 The block SHALL have port divisor, input, N bits: unsigned divisor, sampled on the accepting edge.
REQ-007 The block SHALL have port quotient, output, N bits: unsigned quotient.
REQ-008 The block SHALL have port remainder, output, N bits: unsigned remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: iteration in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the last accepted operation had divisor == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; accepting latches dividend and divisor internally, after which input changes have no effect.
REQ-014 On acceptance with divisor != 0, the FSM SHALL go to RUN, load the iteration counter with N-1, clear the partial remainder (N+1 bits) and clear div_by_zero.
REQ-015 On acceptance with divisor == 0, the FSM SHALL go directly to DONE on that edge with quotient = all ones, remainder = dividend and div_by_zero = 1, so done is high in the next cycle.
REQ-016 Each RUN edge SHALL perform one iteration: shift the partial remainder left by one, inserting the dividend MSB that remains to be consumed (MSB first).
REQ-017 In the same iteration, the block SHALL compute trial = partial remainder - {1'b0, divisor} in N+1 bits.
REQ-018 If trial is non-negative, the partial remainder SHALL take trial and the quotient bit SHALL be 1; otherwise the partial remainder SHALL be restored and the quotient bit SHALL be 0.
REQ-019 The iteration counter SHALL decrement once per RUN edge; the edge with counter == 0 SHALL be the last iteration, SHALL load the quotient and remainder outputs, and SHALL move the FSM to DONE.
REQ-020 Latency SHALL be exactly N RUN cycles, with done high in the cycle beginning N edges after the accepting edge (N+1 edges when N = 32 means done after edge 32), for exactly one cycle.
REQ-021 busy SHALL be 1 in RUN only.
REQ-022 done SHALL be 1 in DONE only.
REQ-023 From DONE without start, the FSM SHALL return to IDLE on the next edge.
REQ-024 From DONE with start, a new operation SHALL be accepted (back-to-back) and done SHALL drop.
REQ-025 start while in RUN SHALL be ignored and SHALL NOT alter the operation in progress.
REQ-026 quotient, remainder and div_by_zero SHALL hold their last values until the completion of the next accepted operation; they SHALL NOT change during RUN.
REQ-027 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0, with no overflow at any N-bit operand values.

Reset
REQ-028 While rst_n = 0, regardless of clk, the FSM SHALL be IDLE and quotient, remainder, the counter and all internal registers SHALL be 0.
REQ-029 While rst_n = 0, busy, done and div_by_zero SHALL be 0.
REQ-030 Reset asserted during RUN SHALL abort the operation immediately, with no done pulse.
REQ-031 After release, the first start SHALL be accepted on the first rising edge at which rst_n = 1 and start = 1.

Verification
REQ-032 N=32, dividend=100, divisor=7 -> busy for 32 cycles, then done pulse, quotient=14, remainder=2, div_by_zero=0.
REQ-033 dividend=5, divisor=0 -> done in the cycle after acceptance, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never high.
REQ-034 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-035 dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-036 Start 100/7, then assert start with 9/3 at RUN cycle 10 -> second request ignored, result 14/2; then start 9/3 during the done cycle -> accepted, result quotient=3, remainder=0.
REQ-037 Assert rst_n=0 at RUN cycle 16 -> all outputs 0 immediately, no done pulse; a fresh start 100/7 after release -> quotient=14, remainder=2.
